// File: rtl/axi_seq_pkg.sv
// axi_seq_pkg: shared FSM states, queued command record and AXI constants for the command sequencer
package axi_seq_pkg;
  typedef enum logic [1:0] {IDLE, WR_ACT, RD_ACT, DONE} state_t;
  typedef struct packed {
    logic        op;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [31:0] data;
    logic [3:0]  strb;
  } cmd_t;
  localparam logic       OP_WRITE  = 1'b1;
  localparam logic       OP_READ   = 1'b0;
  localparam logic [1:0] RESP_OKAY = 2'b00;
endpackage

// File: rtl/axi_seq_fifo.sv
// axi_seq_fifo: command FIFO with registered full/empty; one slot stays open so full and empty differ by pointer compare
module axi_seq_fifo
  import axi_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  cmd_t din,
  output cmd_t dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  cmd_t mem [DEPTH];
  logic [AW-1:0] wp, rp, wp_n, rp_n;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign wp_n    = wp + AW'(do_push);
  assign rp_n    = rp + AW'(do_pop);
  assign dout    = mem[rp];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      wp    <= wp_n;
      rp    <= rp_n;
      full  <= wp_n + AW'(1) == rp_n;
      empty <= wp_n == rp_n;
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/axi_cmd_sequencer.sv
// axi_cmd_sequencer: queues AXI burst commands and issues them one at a time to the master,
// holding fields until completion and reporting status, errors, timeouts and a done count
module axi_cmd_sequencer
  import axi_seq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  input  logic [31:0] cmd_addr,
  input  logic [7:0]  cmd_len,
  input  logic [1:0]  cmd_burst,
  input  logic [31:0] cmd_data,
  input  logic [3:0]  cmd_strb,
  output logic        wr,
  output logic [31:0] wr_addr,
  output logic [7:0]  wr_burst_len,
  output logic [1:0]  wr_burst_type,
  output logic [31:0] wr_din,
  output logic [3:0]  wr_strbin,
  output logic        rd_go,
  output logic [31:0] rd_addr,
  output logic [7:0]  rd_burst_len,
  output logic [1:0]  rd_burst_type,
  input  logic        wr_done,
  input  logic        rd_done,
  input  logic [1:0]  resp,
  output logic        busy,
  output logic        txn_done,
  output logic        txn_err,
  output logic        timeout_flag,
  output logic [15:0] done_cnt
);
  localparam int TW = $clog2(TIMEOUT);
  state_t state;
  cmd_t cmd_in, head;
  logic [TW-1:0] tcnt;
  logic full, empty, pop, done_in, tmo, err_q;
  assign cmd_in = '{op: cmd_op, addr: cmd_addr, len: cmd_len, burst: cmd_burst, data: cmd_data, strb: cmd_strb};
  axi_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (cmd_valid),
    .pop  (pop),
    .din  (cmd_in),
    .dout (head),
    .full (full),
    .empty(empty)
  );
  assign cmd_ready = !full;
  assign pop       = state == IDLE && !empty;
  assign done_in   = (state == WR_ACT && wr_done) || (state == RD_ACT && rd_done);
  assign tmo       = (state == WR_ACT || state == RD_ACT) && !done_in && tcnt == TW'(TIMEOUT - 1);
  assign wr        = state == WR_ACT;
  assign rd_go     = state == RD_ACT;
  assign busy      = state != IDLE || !empty;
  assign txn_done  = state == DONE;
  assign txn_err   = txn_done && err_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state         <= IDLE;
      tcnt          <= '0;
      err_q         <= 1'b0;
      timeout_flag  <= 1'b0;
      done_cnt      <= '0;
      wr_addr       <= '0;
      wr_burst_len  <= '0;
      wr_burst_type <= '0;
      wr_din        <= '0;
      wr_strbin     <= '0;
      rd_addr       <= '0;
      rd_burst_len  <= '0;
      rd_burst_type <= '0;
    end else if (pop) begin
      state <= head.op == OP_READ ? RD_ACT : WR_ACT;
      tcnt  <= '0;
      if (head.op == OP_WRITE) begin
        wr_addr       <= head.addr;
        wr_burst_len  <= head.len;
        wr_burst_type <= head.burst;
        wr_din        <= head.data;
        wr_strbin     <= head.strb;
      end else begin
        rd_addr       <= head.addr;
        rd_burst_len  <= head.len;
        rd_burst_type <= head.burst;
      end
    end else if (done_in || tmo) begin
      state        <= DONE;
      err_q        <= done_in ? resp != RESP_OKAY : 1'b1;
      timeout_flag <= timeout_flag | tmo;
      done_cnt     <= done_cnt + 16'd1;
    end else if (state == DONE) begin
      state <= IDLE;
    end else if (state != IDLE) begin
      tcnt <= tcnt + TW'(1);
    end
endmodule

// File: tb/tb_axi_cmd_sequencer.sv
// tb_axi_cmd_sequencer: directed table vectors plus hand sequences for queueing, timeout and reset corners
module tb_axi_cmd_sequencer;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_ready, cmd_op = 0;
  logic [31:0] cmd_addr = 0, cmd_data = 0;
  logic [7:0] cmd_len = 0;
  logic [1:0] cmd_burst = 0, resp = 0;
  logic [3:0] cmd_strb = 0;
  logic wr, rd_go, wr_done = 0, rd_done = 0, busy, txn_done, txn_err, timeout_flag;
  logic [31:0] wr_addr, wr_din, rd_addr;
  logic [7:0] wr_burst_len, rd_burst_len;
  logic [1:0] wr_burst_type, rd_burst_type;
  logic [3:0] wr_strbin;
  logic [15:0] done_cnt;
  int pass = 0, total = 0;

  always #5 clk = ~clk;

  axi_cmd_sequencer #(.DEPTH(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_burst(cmd_burst), .cmd_data(cmd_data),
    .cmd_strb(cmd_strb), .wr(wr), .wr_addr(wr_addr), .wr_burst_len(wr_burst_len),
    .wr_burst_type(wr_burst_type), .wr_din(wr_din), .wr_strbin(wr_strbin), .rd_go(rd_go),
    .rd_addr(rd_addr), .rd_burst_len(rd_burst_len), .rd_burst_type(rd_burst_type),
    .wr_done(wr_done), .rd_done(rd_done), .resp(resp), .busy(busy), .txn_done(txn_done),
    .txn_err(txn_err), .timeout_flag(timeout_flag), .done_cnt(done_cnt)
  );

  typedef struct {
    logic        op;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  r;
    logic        err;
  } vec_t;
  vec_t vt [6];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic set_cmd(input logic op, input logic [31:0] a, input logic [7:0] l,
                         input logic [1:0] b, input logic [31:0] d, input logic [3:0] s);
    cmd_valid = 1; cmd_op = op; cmd_addr = a; cmd_len = l; cmd_burst = b; cmd_data = d; cmd_strb = s;
  endtask

  task automatic push(input logic op, input logic [31:0] a, input logic [7:0] l,
                      input logic [1:0] b, input logic [31:0] d, input logic [3:0] s);
    set_cmd(op, a, l, b, d, s);
    step;
    cmd_valid = 0;
  endtask

  task automatic finish_one(input logic [1:0] r);
    int n = 0;
    while (!(wr || rd_go) && n < 20) begin step; n++; end
    chk("drain_active", 32'(wr | rd_go), 1);
    if (wr) wr_done = 1; else rd_done = 1;
    resp = r;
    step;
    wr_done = 0; rd_done = 0; resp = 0;
    chk("drain_txn_done", 32'(txn_done), 1);
    step;
  endtask

  initial begin
    vt[0] = '{1'b1, 32'h1,        8'd4,   2'd1, 32'h5,        4'hF, 2'b00, 1'b0};
    vt[1] = '{1'b0, 32'h1,        8'd4,   2'd0, 32'h0,        4'h0, 2'b00, 1'b0};
    vt[2] = '{1'b1, 32'h1000,     8'd0,   2'd2, 32'hDEADBEEF, 4'h3, 2'b10, 1'b1};
    vt[3] = '{1'b0, 32'hFFFFFFFC, 8'd255, 2'd1, 32'h0,        4'h0, 2'b11, 1'b1};
    vt[4] = '{1'b1, 32'h80000000, 8'd7,   2'd1, 32'hA5A5,     4'h8, 2'b01, 1'b1};
    vt[5] = '{1'b0, 32'h40,       8'd15,  2'd2, 32'h0,        4'h0, 2'b00, 1'b0};
    step; step;
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_wr", 32'(wr), 0);
    chk("rst_rd_go", 32'(rd_go), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_txn_done", 32'(txn_done), 0);
    chk("rst_timeout_flag", 32'(timeout_flag), 0);
    chk("rst_done_cnt", 32'(done_cnt), 0);
    chk("rst_wr_addr", wr_addr, 0);
    rst = 0;
    step;
    for (int i = 0; i < 6; i++) begin
      push(vt[i].op, vt[i].addr, vt[i].len, vt[i].burst, vt[i].data, vt[i].strb);
      chk($sformatf("v%0d_not_yet", i), 32'(wr | rd_go), 0);
      step;
      chk($sformatf("v%0d_wr", i), 32'(wr), 32'(vt[i].op));
      chk($sformatf("v%0d_rd_go", i), 32'(rd_go), 32'(!vt[i].op));
      if (vt[i].op) begin
        chk($sformatf("v%0d_wr_addr", i), wr_addr, vt[i].addr);
        chk($sformatf("v%0d_wr_len", i), 32'(wr_burst_len), 32'(vt[i].len));
        chk($sformatf("v%0d_wr_burst", i), 32'(wr_burst_type), 32'(vt[i].burst));
        chk($sformatf("v%0d_wr_din", i), wr_din, vt[i].data);
        chk($sformatf("v%0d_wr_strb", i), 32'(wr_strbin), 32'(vt[i].strb));
        wr_done = 1;
      end else begin
        chk($sformatf("v%0d_rd_addr", i), rd_addr, vt[i].addr);
        chk($sformatf("v%0d_rd_len", i), 32'(rd_burst_len), 32'(vt[i].len));
        chk($sformatf("v%0d_rd_burst", i), 32'(rd_burst_type), 32'(vt[i].burst));
        rd_done = 1;
      end
      resp = vt[i].r;
      step;
      wr_done = 0; rd_done = 0; resp = 0;
      chk($sformatf("v%0d_txn_done", i), 32'(txn_done), 1);
      chk($sformatf("v%0d_txn_err", i), 32'(txn_err), 32'(vt[i].err));
      chk($sformatf("v%0d_active_low", i), 32'(wr | rd_go), 0);
      chk($sformatf("v%0d_done_cnt", i), 32'(done_cnt), 32'(i + 1));
      step;
      chk($sformatf("v%0d_done_pulse", i), 32'(txn_done), 0);
    end
    // write then read queued back-to-back, with a stray rd_done during the write
    push(1'b1, 32'h1, 8'd4, 2'd1, 32'h5, 4'hF);
    push(1'b0, 32'h1, 8'd4, 2'd0, 32'h0, 4'h0);
    chk("b2b_wr_active", 32'(wr), 1);
    rd_done = 1; resp = 2'b10;
    step;
    rd_done = 0; resp = 0;
    chk("stray_rd_done_wr", 32'(wr), 1);
    chk("stray_rd_done_txn", 32'(txn_done), 0);
    wr_done = 1;
    step;
    wr_done = 0;
    chk("b2b_done_gap", 32'({wr, rd_go}), 0);
    chk("b2b_wr_err", 32'(txn_err), 0);
    step;
    chk("b2b_idle_gap", 32'({wr, rd_go}), 0);
    step;
    chk("b2b_rd_go", 32'({wr, rd_go}), 1);
    chk("b2b_rd_burst", 32'(rd_burst_type), 0);
    rd_done = 1;
    step;
    rd_done = 0;
    chk("b2b_done_cnt", 32'(done_cnt), 8);
    step;
    // fill: one active plus DEPTH-1 queued, extra command held off
    begin
      int acc = 0;
      set_cmd(1'b1, 32'h200, 8'd1, 2'd1, 32'h77, 4'hF);
      for (int k = 0; k < 6; k++) begin
        if (cmd_ready) acc++;
        step;
      end
      cmd_valid = 0;
      chk("full_accepted", 32'(acc), 4);
      chk("full_ready_low", 32'(cmd_ready), 0);
      chk("full_busy", 32'(busy), 1);
    end
    wr_done = 1;
    step;
    wr_done = 0;
    chk("full_ready_in_done", 32'(cmd_ready), 0);
    step;
    step;
    chk("full_ready_after_pop", 32'(cmd_ready), 1);
    for (int k = 0; k < 3; k++) finish_one(2'b00);
    chk("full_done_cnt", 32'(done_cnt), 12);
    chk("full_drained_busy", 32'(busy), 0);
    // done pulse on the last allowed ACT cycle beats the timeout
    push(1'b1, 32'h300, 8'd0, 2'd1, 32'h1, 4'h1);
    step;
    for (int k = 0; k < 14; k++) step;
    chk("edge_still_active", 32'(wr), 1);
    step;
    wr_done = 1;
    step;
    wr_done = 0;
    chk("edge_txn_done", 32'(txn_done), 1);
    chk("edge_txn_err", 32'(txn_err), 0);
    chk("edge_no_timeout_flag", 32'(timeout_flag), 0);
    step;
    // read that never completes is aborted after TIMEOUT cycles
    push(1'b0, 32'h400, 8'd3, 2'd1, 32'h0, 4'h0);
    step;
    begin
      int n = 0;
      while (rd_go && n < 40) begin n++; step; end
      chk("tmo_act_cycles", 32'(n), 16);
    end
    chk("tmo_txn_done", 32'(txn_done), 1);
    chk("tmo_txn_err", 32'(txn_err), 1);
    chk("tmo_flag", 32'(timeout_flag), 1);
    chk("tmo_done_cnt", 32'(done_cnt), 14);
    step;
    chk("tmo_flag_sticky", 32'(timeout_flag), 1);
    // asynchronous reset mid-write with two commands queued
    push(1'b1, 32'h500, 8'd0, 2'd1, 32'h1, 4'hF);
    push(1'b1, 32'h504, 8'd0, 2'd1, 32'h2, 4'hF);
    push(1'b1, 32'h508, 8'd0, 2'd1, 32'h3, 4'hF);
    chk("rstmid_wr_before", 32'(wr), 1);
    #2 rst = 1;
    #1;
    chk("rstmid_wr", 32'(wr), 0);
    chk("rstmid_busy", 32'(busy), 0);
    chk("rstmid_done_cnt", 32'(done_cnt), 0);
    chk("rstmid_flag", 32'(timeout_flag), 0);
    step;
    rst = 0;
    for (int k = 0; k < 4; k++) begin
      step;
      chk($sformatf("rstmid_quiet%0d", k), 32'({wr, rd_go, busy, txn_done}), 0);
    end
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/axi_cmd_sequencer.md
# axi_cmd_sequencer

Command sequencer that sits directly upstream of the AXI-full master/slave pair (`connect_m_s`) and drives its user command port. It buffers queued write/read burst commands in a small FIFO and issues them to the master one at a time. Each set of command fields is held stable until the master reports completion (B handshake for writes, last R beat for reads). It also reports per-transaction status, error/timeout flags and a completion count.

## Interface
Parameters:
- DEPTH, 4, command FIFO entries (power of 2, ≥2)
- TIMEOUT, 1024, max cycles a transaction may stay active before abort (≥2)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO not full
- cmd_op  in  1  1 = write, 0 = read
- cmd_addr  in  32  start address
- cmd_len  in  8  AXI burst length (beats − 1)
- cmd_burst  in  2  AXI burst type
- cmd_data  in  32  write data (ignored for reads)
- cmd_strb  in  4  write strobes (ignored for reads)
- wr  out  1  write transaction active (to master)
- wr_addr / wr_burst_len / wr_burst_type / wr_din / wr_strbin  out  32/8/2/32/4  write command fields
- rd_go  out  1  read transaction active
- rd_addr / rd_burst_len / rd_burst_type  out  32/8/2  read command fields
- wr_done  in  1  one-cycle pulse on master B handshake (bvalid & bready)
- rd_done  in  1  one-cycle pulse on master R handshake with rlast
- resp  in  2  bresp/rresp, valid in the wr_done/rd_done cycle
- busy  out  1  state ≠ IDLE or FIFO non-empty
- txn_done  out  1  one-cycle pulse per finished command
- txn_err  out  1  one-cycle pulse with txn_done when resp ≠ OKAY or timeout
- timeout_flag  out  1  sticky; set on any timeout, cleared only by rst
- done_cnt  out  16  completed commands, wraps 0xFFFF→0

## Operation
- FIFO push on cmd_valid & cmd_ready. cmd_ready = !full, registered. No push while full, even if a pop happens in the same cycle.
- FSM states: IDLE, WR_ACT, RD_ACT, DONE.
- IDLE: if the FIFO is non-empty, pop the head, load the output registers, go to WR_ACT (op=1) or RD_ACT (op=0). No same-cycle bypass from the push.
- WR_ACT: wr=1, all wr_* fields held. On wr_done, capture resp, go to DONE.
- RD_ACT: rd_go=1, rd_* fields held. On rd_done, capture resp, go to DONE.
- Timeout counter clears on entry to an ACT state and increments every ACT cycle. If it reaches TIMEOUT−1 with no done pulse: go to DONE, set err, set timeout_flag.
- DONE (1 cycle): wr=0 and rd_go=0. txn_done=1. txn_err=1 if captured resp≠2'b00 or a timeout occurred. done_cnt increments. Go to IDLE.
- wr_done/rd_done arriving outside the matching ACT state are ignored. A wr_done during RD_ACT is ignored, and vice versa.
- Field registers keep their last value when idle. wr and rd_go are never both 1.

## Timing
- Reset value of all outputs is 0, except cmd_ready=1. FIFO is emptied and the FSM goes to IDLE.
- Reset mid-transaction aborts the command. Queued commands are lost, no txn_done is produced, done_cnt=0.
- Latency: command accepted at edge N → wr/rd_go high after edge N+2.
- Done pulse at edge M → wr/rd_go low after edge M+1, txn_done high in that same cycle. The next command's active level starts no earlier than edge M+2. This guarantees at least one idle cycle between transactions, so the master sees wr deassert.
- Back-to-back throughput is one command per ACT duration + 2 cycles.
- Done pulse and timeout in the same cycle: the done pulse wins; resp is used and timeout_flag is not set.

## Structure
- Package axi_seq_pkg holds:
  - state enum (IDLE, WR_ACT, RD_ACT, DONE)
  - cmd_t struct: op, addr, len, burst, data, strb
  - constants OP_WRITE=1, OP_READ=0, RESP_OKAY=2'b00
- Sub-module axi_seq_fifo: synchronous FIFO of cmd_t, DEPTH entries, full/empty flags, async active-high reset.
- The top level contains the FSM, timeout counter, status logic and output registers.

## Test plan
- Reset release, push one write (addr 0x1, len 4, INCR, data 0x5, strb 0xF) → wr=1 two cycles later with those fields. Pulse wr_done with resp=0 → txn_done=1, txn_err=0, done_cnt=1.
- Write then read (addr 0x1, len 4, FIXED) queued back-to-back → wr falls, one cycle with wr=0 and rd_go=0, then rd_go=1. rd_done → done_cnt=2.
- Push DEPTH+1 commands with no completions → cmd_ready=0 after DEPTH−1 queued plus 1 active. The extra command is not accepted until one completes.
- Read with no rd_done, TIMEOUT=16 → abort after 16 ACT cycles. txn_done=1 and txn_err=1 together, timeout_flag stays 1.
- wr_done with resp=2'b10 → txn_err pulse. Stray rd_done during WR_ACT → no state change.
- rst asserted during WR_ACT with 2 queued → wr=0 immediately, busy=0, done_cnt=0. After release, no command is issued.
